// File: rtl/pkg_botoes.sv
// Shared types and constants for the push-button conditioner.
// Debounce FSM state encoding and default debounce length.
package pkg_botoes;

  typedef enum logic [1:0] {
    SOLTO,
    CONFIRMA_PRESS,
    PRESSIONADO,
    CONFIRMA_SOLTA
  } estado_botao_t;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/debouncer_botao.sv
// One button channel: 2-flop synchroniser, debounce FSM, press pulse.
// Ports: clk, rst (async active-low), bruto, habilitar -> estavel, pulso.
module debouncer_botao
  import pkg_botoes::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic bruto,
  input  logic habilitar,
  output logic estavel,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] ALVO = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_CICLOS);

  logic [1:0]    sinc;
  logic          s;
  estado_botao_t estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          est_q, est_d;
  logic          pulso_q, pulso_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sinc <= 2'b00;
    end else begin
      sinc <= {sinc[0], bruto};
    end
  end

  assign s = sinc[1];

  // Counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == SAT) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= SOLTO;
      cnt_q    <= '0;
      est_q    <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      est_q    <= est_d;
      pulso_q  <= pulso_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    est_d    = est_q;
    pulso_d  = 1'b0;
    unique case (estado_q)
      SOLTO: begin
        if (s) begin
          estado_d = CONFIRMA_PRESS;
          cnt_d    = CW'(1);
        end else begin
          cnt_d    = '0;
        end
      end
      CONFIRMA_PRESS: begin
        if (!s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q == ALVO) begin
          estado_d = PRESSIONADO;
          est_d    = 1'b1;
          // Dropped, not queued, when disabled.
          pulso_d  = habilitar;
        end else begin
          cnt_d    = cnt_inc;
        end
      end
      PRESSIONADO: begin
        if (!s) begin
          estado_d = CONFIRMA_SOLTA;
          cnt_d    = CW'(1);
        end
      end
      CONFIRMA_SOLTA: begin
        if (s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == ALVO) begin
          estado_d = SOLTO;
          est_d    = 1'b0;
        end else begin
          cnt_d    = cnt_inc;
        end
      end
      default: begin
        estado_d = SOLTO;
        cnt_d    = '0;
      end
    endcase
  end

  assign estavel = est_q;
  assign pulso   = pulso_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Conditions raw buttons into debounced levels and one-cycle press pulses.
// Ports: clk, rst (async active-low), botoes_brutos, habilitar ->
//   botoes_estavel, botoes_pulso, algum_pulso.
module condicionador_botoes
  import pkg_botoes::*;
#(
  parameter int N_BOTOES        = 6,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  input  logic                habilitar,
  output logic [N_BOTOES-1:0] botoes_estavel,
  output logic [N_BOTOES-1:0] botoes_pulso,
  output logic                algum_pulso
);

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    debouncer_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .bruto    (botoes_brutos[i]),
      .habilitar(habilitar),
      .estavel  (botoes_estavel[i]),
      .pulso    (botoes_pulso[i])
    );
  end

  assign algum_pulso = |botoes_pulso;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed self-checking bench for condicionador_botoes.
// Runs with DEBOUNCE_CICLOS=4: pulses land 5 edges after first sample.
module tb_condicionador_botoes;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] brutos;
  logic       hab;
  logic [5:0] estavel;
  logic [5:0] pulso;
  logic       algum;

  int vec = 0;
  int err = 0;

  condicionador_botoes #(
    .N_BOTOES(6),
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .botoes_brutos (brutos),
    .habilitar     (hab),
    .botoes_estavel(estavel),
    .botoes_pulso  (pulso),
    .algum_pulso   (algum)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    brutos = '0;
    hab = 1'b1;
    #1;
    vec++;
    if (estavel !== 6'b0 || pulso !== 6'b0 || algum !== 1'b0) begin
      err++;
      $display("FAIL reset_async est=%b pul=%b any=%b exp 0",
               estavel, pulso, algum);
    end
    idle(3);
    vec++;
    if (estavel !== 6'b0 || pulso !== 6'b0 || algum !== 1'b0) begin
      err++;
      $display("FAIL reset_held est=%b pul=%b any=%b exp 0",
               estavel, pulso, algum);
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_clean_press;
    @(negedge clk);
    brutos[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      vec++;
      if (pulso[0] !== (k == 5) || algum !== (k == 5)) begin
        err++;
        $display("FAIL clean_pulse k=%0d got %b/%b exp %b",
                 k, pulso[0], algum, k == 5);
      end
      vec++;
      if (estavel[0] !== (k >= 5)) begin
        err++;
        $display("FAIL clean_est k=%0d got %b exp %b",
                 k, estavel[0], k >= 5);
      end
    end
    @(negedge clk);
    brutos[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vec++;
      if (estavel[0] !== (k < 5) || pulso[0] !== 1'b0) begin
        err++;
        $display("FAIL clean_release k=%0d est=%b pul=%b exp %b/0",
                 k, estavel[0], pulso[0], k < 5);
      end
    end
    idle(2);
  endtask

  task automatic test_bounce;
    logic [4:0] pat;
    pat = 5'b01101;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      brutos[1] = (k < 5) ? pat[k] : 1'b1;
      @(posedge clk); #1;
      vec++;
      if (pulso[1] !== (k == 10) || estavel[1] !== (k >= 10)) begin
        err++;
        $display("FAIL bounce k=%0d pul=%b est=%b exp %b/%b",
                 k, pulso[1], estavel[1], k == 10, k >= 10);
      end
    end
    @(negedge clk);
    brutos[1] = 1'b0;
    idle(10);
    vec++;
    if (estavel[1] !== 1'b0) begin
      err++;
      $display("FAIL bounce_release got %b exp 0", estavel[1]);
    end
  endtask

  task automatic test_release_bounce;
    logic [2:0] pat;
    int npul;
    pat = 3'b010;
    npul = 0;
    @(negedge clk);
    brutos[2] = 1'b1;
    idle(10);
    vec++;
    if (estavel[2] !== 1'b1) begin
      err++;
      $display("FAIL relb_hold got %b exp 1", estavel[2]);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      brutos[2] = (k < 3) ? pat[k] : 1'b0;
      @(posedge clk); #1;
      if (pulso[2]) npul++;
      vec++;
      if (estavel[2] !== (k < 7)) begin
        err++;
        $display("FAIL relb_est k=%0d got %b exp %b",
                 k, estavel[2], k < 7);
      end
    end
    vec++;
    if (npul !== 0) begin
      err++;
      $display("FAIL relb_pulses got %0d exp 0", npul);
    end
    idle(2);
  endtask

  task automatic test_habilitar;
    @(negedge clk);
    hab = 1'b0;
    brutos[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vec++;
      if (pulso[3] !== 1'b0 || estavel[3] !== (k >= 5)) begin
        err++;
        $display("FAIL hab_off k=%0d pul=%b est=%b exp 0/%b",
                 k, pulso[3], estavel[3], k >= 5);
      end
    end
    @(negedge clk);
    brutos[3] = 1'b0;
    idle(10);
    hab = 1'b1;
    brutos[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      vec++;
      if (pulso[3] !== (k == 5)) begin
        err++;
        $display("FAIL hab_on k=%0d got %b exp %b",
                 k, pulso[3], k == 5);
      end
    end
    @(negedge clk);
    brutos[3] = 1'b0;
    idle(10);
  endtask

  task automatic test_simultaneous;
    logic [5:0] exp_p;
    @(negedge clk);
    brutos[0] = 1'b1;
    brutos[5] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      exp_p = (k == 5) ? 6'b100001 : 6'b000000;
      vec++;
      if (pulso !== exp_p || algum !== (k == 5)) begin
        err++;
        $display("FAIL simult k=%0d got %b/%b exp %b/%b",
                 k, pulso, algum, exp_p, k == 5);
      end
    end
    @(negedge clk);
    brutos[0] = 1'b0;
    brutos[5] = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    brutos[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    vec++;
    if (estavel !== 6'b0 || pulso !== 6'b0 || algum !== 1'b0) begin
      err++;
      $display("FAIL rstmid_now est=%b pul=%b any=%b exp 0",
               estavel, pulso, algum);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vec++;
      if (pulso !== 6'b0 || estavel !== 6'b0) begin
        err++;
        $display("FAIL rstmid_hold k=%0d pul=%b est=%b exp 0",
                 k, pulso, estavel);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      vec++;
      if (pulso[4] !== (k == 5) || estavel[4] !== (k >= 5)) begin
        err++;
        $display("FAIL rstmid_after k=%0d pul=%b est=%b exp %b/%b",
                 k, pulso[4], estavel[4], k == 5, k >= 5);
      end
    end
    @(negedge clk);
    brutos[4] = 1'b0;
    idle(10);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_release_bounce;
    test_habilitar;
    test_simultaneous;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
